// File: rtl/mem_dbg_master_if.sv
// Debug command/response channel plus PicoRV32 native memory bus.
// The master modport is the debug bridge; the slave modport is the host and
// memory side of the same signals.
interface mem_dbg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
           mem_ready, mem_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
           mem_ready, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_dbg_master.sv
// Debug memory bridge: one byte/half/word command at a time is turned into a
// single native-bus request. Misaligned or reserved-size commands answer with
// err=1 and never touch the bus; a request left unanswered for TIMEOUT_CYCLES
// is dropped with err=2 (TIMEOUT_CYCLES=0 waits forever).
//
//  state  | meaning
//  IDLE   | cmd_ready high, waiting for a command
//  BUS    | mem_valid high, waiting for mem_ready or timeout
//  RESP   | rsp_valid high, holding the response until rsp_ready
module mem_dbg_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_dbg_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cmd_ready_w;
  logic        cmd_bad;
  logic        timeout_hit;
  logic [31:0] rd_shift;
  logic [31:0] rd_lane;
  logic [3:0]  strb;

  // cmd_ready is gated by reset so it is low while reset is held and high in
  // the very first cycle after release.
  assign cmd_ready_w = (state_q == S_IDLE) && !rst_i;

  assign cmd_bad = (bus.cmd_size == 2'd3) ||
                   ((bus.cmd_size == 2'd1) && bus.cmd_addr[0]) ||
                   ((bus.cmd_size == 2'd2) && (bus.cmd_addr[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  assign rd_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign rd_lane  = (size_q == 2'd0) ? {24'b0, rd_shift[7:0]}  :
                    (size_q == 2'd1) ? {16'b0, rd_shift[15:0]} : rd_shift;

  assign strb = (size_q == 2'd0) ? (4'b0001 << addr_q[1:0]) :
                (size_q == 2'd1) ? (4'b0011 << addr_q[1:0]) : 4'b1111;

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_valid = (state_q == S_BUS);
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wstrb = ((state_q == S_BUS) && write_q) ? strb : 4'b0000;
  assign bus.mem_wdata = (size_q == 2'd0) ? {4{wdata_q[7:0]}}  :
                         (size_q == 2'd1) ? {2{wdata_q[15:0]}} : wdata_q;

  // Next-state and datapath update for the command/bus/response sequence.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_w) begin
          write_d = bus.cmd_write;
          size_d  = bus.cmd_size;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          rdata_d = 32'b0;
          cnt_d   = '0;
          if (cmd_bad) begin
            err_d   = 2'd1;
            state_d = S_RESP;
          end else begin
            err_d   = 2'd0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // mem_ready in the terminal-count cycle still completes normally.
        if (bus.mem_ready) begin
          rdata_d = write_q ? 32'b0 : rd_lane;
          err_d   = 2'd0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = 32'b0;
          err_d   = 2'd2;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latched command fields, response payload and timeout counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_dbg_master.sv
// Bench for mem_dbg_master: directed scenarios plus 1000 random commands with
// random responder latency and response stalls, checked against a byte-level
// memory model and a latency/outcome model derived from the command rules.
module tb_mem_dbg_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  mem_dbg_master_if ifc();

  mem_dbg_master #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifc.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder control / observations
  int          cur_delay    = -1;
  int          valid_cycles = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;
  bit          obs_unstable, obs_instr;
  // Response observations
  int          obs_lat;
  logic [1:0]  obs_err;
  logic [31:0] obs_rdata;
  bit          rsp_unstable;

  logic [31:0] bus_mem [bit [31:0]];
  logic [7:0]  ref_mem [bit [31:0]];
  logic [31:0] xs_state = 32'h1234_5678;

  function automatic logic [31:0] init_word(input bit [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] bus_read(input bit [31:0] a);
    bit [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (bus_mem.exists(wa)) return bus_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input bit [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
    return w[7:0];
  endfunction

  function automatic logic [31:0] xs_next();
    xs_state = xs_state ^ (xs_state << 13);
    xs_state = xs_state ^ (xs_state >> 17);
    xs_state = xs_state ^ (xs_state << 5);
    return xs_state;
  endfunction

  task automatic preload(input bit [31:0] wa, input logic [31:0] w);
    bus_mem[wa] = w;
    for (int i = 0; i < 4; i++) ref_mem[wa + i] = w[8*i +: 8];
  endtask

  // Memory responder: mem_ready after cur_delay cycles of mem_valid
  // (negative delay = never); writes land in bus_mem via the strobes.
  always @(negedge clk) begin
    logic [31:0] w;
    if (ifc.mem_valid === 1'b1) begin
      if (valid_cycles == 0) begin
        obs_addr  = ifc.mem_addr;
        obs_strb  = ifc.mem_wstrb;
        obs_wdata = ifc.mem_wdata;
      end else if (obs_addr !== ifc.mem_addr || obs_strb !== ifc.mem_wstrb ||
                   obs_wdata !== ifc.mem_wdata) begin
        obs_unstable = 1'b1;
      end
      if (ifc.mem_instr !== 1'b0) obs_instr = 1'b1;
      ifc.mem_rdata = bus_read(ifc.mem_addr);
      if (valid_cycles == cur_delay) begin
        ifc.mem_ready = 1'b1;
        w = bus_read(ifc.mem_addr);
        for (int j = 0; j < 4; j++)
          if (ifc.mem_wstrb[j]) w[8*j +: 8] = ifc.mem_wdata[8*j +: 8];
        if (|ifc.mem_wstrb) bus_mem[{ifc.mem_addr[31:2], 2'b00}] = w;
      end else begin
        ifc.mem_ready = 1'b0;
      end
      valid_cycles++;
    end else begin
      if (ifc.mem_instr !== 1'b0) obs_instr = 1'b1;
      ifc.mem_ready = 1'b0;
      ifc.mem_rdata = $urandom;
    end
  end

  // Issue one command, collect its response after `stall` cycles of
  // rsp_ready low. obs_lat counts cycles from accept to rsp_valid.
  task automatic do_cmd(input bit wr, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input int dly, input int stall);
    int k;
    cur_delay    = dly;
    valid_cycles = 0;
    obs_unstable = 1'b0;
    obs_instr    = 1'b0;
    rsp_unstable = 1'b0;
    obs_err      = 2'bxx;
    obs_rdata    = 'x;
    obs_addr     = 'x;
    obs_strb     = 'x;
    obs_wdata    = 'x;
    @(negedge clk);
    k = 0;
    while (ifc.cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (ifc.cmd_ready !== 1'b1) begin obs_lat = -2; return; end
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_size  = sz;
    ifc.cmd_addr  = ad;
    ifc.cmd_wdata = wd;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_addr  = $urandom;
    ifc.cmd_wdata = $urandom;
    k = 1;
    while (ifc.rsp_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (ifc.rsp_valid !== 1'b1) begin obs_lat = -1; return; end
    obs_lat   = k;
    obs_err   = ifc.rsp_err;
    obs_rdata = ifc.rsp_rdata;
    repeat (stall) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== obs_err || ifc.rsp_rdata !== obs_rdata)
        rsp_unstable = 1'b1;
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
  endtask

  // Reference: outcome, payload and bus shape of one command.
  task automatic model_expect(input bit wr, input logic [1:0] sz, input logic [31:0] ad,
                              input logic [31:0] wd, input int dly,
                              output logic [1:0] e_err, output logic [31:0] e_rdata,
                              output int e_lat, output int e_vcyc,
                              output logic [3:0] e_strb, output logic [31:0] e_wdata);
    int n, off;
    bit bad, timed;
    n       = 1 << sz;
    off     = ad % 4;
    bad     = (sz == 2'd3) || ((ad % n) != 0);
    e_rdata = 32'b0;
    e_strb  = 4'b0;
    e_wdata = 32'b0;
    if (bad) begin
      e_err = 2'd1; e_lat = 1; e_vcyc = 0;
      return;
    end
    timed  = !(dly >= 0 && dly < TO);
    e_vcyc = timed ? TO : dly + 1;
    e_lat  = e_vcyc + 1;
    e_err  = timed ? 2'd2 : 2'd0;
    if (!timed && !wr)
      for (int i = 0; i < n; i++) e_rdata[8*i +: 8] = ref_byte(ad + i);
    for (int j = 0; j < 4; j++) begin
      if (wr && j >= off && j < off + n) e_strb[j] = 1'b1;
      e_wdata[8*j +: 8] = wd[8*(j % n) +: 8];
    end
  endtask

  task automatic model_commit(input bit wr, input logic [1:0] sz, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [1:0] e_err);
    if (wr && e_err == 2'd0)
      for (int i = 0; i < (1 << sz); i++) ref_mem[ad + i] = wd[8*i +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ifc.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", ifc.cmd_ready); end
    n_checks++;
    if (ifc.mem_valid !== 1'b0 || ifc.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: mem_valid=%b rsp_valid=%b expected 0/0", ifc.mem_valid, ifc.rsp_valid);
    end
    n_checks++;
    if (ifc.rsp_rdata !== 32'b0 || ifc.rsp_err !== 2'b0 || ifc.mem_addr !== 32'b0 ||
        ifc.mem_wdata !== 32'b0 || ifc.mem_wstrb !== 4'b0 || ifc.mem_instr !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: rdata=%h err=%0d addr=%h wdata=%h wstrb=%b instr=%b expected all 0",
                         ifc.rsp_rdata, ifc.rsp_err, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, ifc.mem_instr);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", ifc.cmd_ready); end
  endtask

  task automatic test_word_read();
    preload(32'h100, 32'hDEAD_BEEF);
    do_cmd(1'b0, 2'd2, 32'h100, 32'h0, 0, 0);
    n_checks++;
    if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 2'd0) begin
      n_fail++; $display("FAIL word_read: rdata=%h err=%0d expected deadbeef/0", obs_rdata, obs_err);
    end
    n_checks++;
    if (obs_lat != 2) begin n_fail++; $display("FAIL word_read_latency: got %0d expected 2", obs_lat); end
    n_checks++;
    if (obs_strb !== 4'b0000 || valid_cycles != 1) begin
      n_fail++; $display("FAIL word_read_bus: wstrb=%b valid_cycles=%0d expected 0000/1", obs_strb, valid_cycles);
    end
  endtask

  task automatic test_byte_write();
    do_cmd(1'b1, 2'd0, 32'h103, 32'h1234_56A5, 1, 1);
    n_checks++;
    if (obs_addr !== 32'h100 || obs_strb !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL byte_write_bus: addr=%h wstrb=%b wdata=%h expected 00000100/1000/a5a5a5a5",
                         obs_addr, obs_strb, obs_wdata);
    end
    n_checks++;
    if (obs_err !== 2'd0 || obs_rdata !== 32'b0 || obs_lat != 3) begin
      n_fail++; $display("FAIL byte_write_rsp: err=%0d rdata=%h lat=%0d expected 0/0/3", obs_err, obs_rdata, obs_lat);
    end
  endtask

  task automatic test_half_read();
    preload(32'h100, 32'h1234_5678);
    do_cmd(1'b0, 2'd1, 32'h102, 32'h0, 2, 0);
    n_checks++;
    if (obs_rdata !== 32'h0000_1234 || obs_err !== 2'd0) begin
      n_fail++; $display("FAIL half_read: rdata=%h err=%0d expected 00001234/0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_errors();
    do_cmd(1'b0, 2'd1, 32'h101, 32'h0, 0, 0);
    n_checks++;
    if (obs_err !== 2'd1 || obs_rdata !== 32'b0 || valid_cycles != 0 || obs_lat != 1) begin
      n_fail++; $display("FAIL err_misaligned_half: err=%0d rdata=%h valid_cycles=%0d lat=%0d expected 1/0/0/1",
                         obs_err, obs_rdata, valid_cycles, obs_lat);
    end
    do_cmd(1'b1, 2'd3, 32'h100, 32'hFFFF_FFFF, 0, 2);
    n_checks++;
    if (obs_err !== 2'd1 || valid_cycles != 0 || rsp_unstable) begin
      n_fail++; $display("FAIL err_reserved_size: err=%0d valid_cycles=%0d unstable=%0d expected 1/0/0",
                         obs_err, valid_cycles, rsp_unstable);
    end
  endtask

  task automatic test_timeout();
    do_cmd(1'b0, 2'd2, 32'h108, 32'h0, -1, 0);
    n_checks++;
    if (valid_cycles != TO || obs_err !== 2'd2 || obs_rdata !== 32'b0) begin
      n_fail++; $display("FAIL timeout: valid_cycles=%0d err=%0d rdata=%h expected %0d/2/0",
                         valid_cycles, obs_err, obs_rdata, TO);
    end
    n_checks++;
    if (obs_lat != TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", obs_lat, TO + 1); end
    preload(32'h10C, 32'hCAFE_F00D);
    do_cmd(1'b0, 2'd2, 32'h10C, 32'h0, TO - 1, 0);
    n_checks++;
    if (valid_cycles != TO || obs_err !== 2'd0 || obs_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL ready_at_last_cycle: valid_cycles=%0d err=%0d rdata=%h expected %0d/0/cafef00d",
                         valid_cycles, obs_err, obs_rdata, TO);
    end
  endtask

  task automatic test_random(input int n_cmds);
    bit          wr;
    logic [1:0]  sz, e_err;
    logic [31:0] ad, wd, e_rdata, e_wdata;
    logic [3:0]  e_strb;
    int          dly, stall, e_lat, e_vcyc, r;
    for (int c = 0; c < n_cmds; c++) begin
      wr = $urandom_range(0, 1);
      r  = $urandom_range(0, 15);
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      ad = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~((32'd1 << sz) - 1);
      wd = $urandom;
      r  = xs_next() % 16;
      dly = (r < 10) ? r % 3 : (r < 13) ? 3 + (r % 5) : (r == 13) ? TO - 1 : (r == 14) ? TO : -1;
      stall = $urandom_range(0, 3);
      model_expect(wr, sz, ad, wd, dly, e_err, e_rdata, e_lat, e_vcyc, e_strb, e_wdata);
      do_cmd(wr, sz, ad, wd, dly, stall);
      n_checks++;
      if (obs_err !== e_err || obs_rdata !== e_rdata) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: err=%0d rdata=%h expected %0d/%h (wr=%0d sz=%0d addr=%h)",
                           c, obs_err, obs_rdata, e_err, e_rdata, wr, sz, ad);
      end
      n_checks++;
      if (obs_lat != e_lat || valid_cycles != e_vcyc) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d valid_cycles=%0d expected %0d/%0d",
                           c, obs_lat, valid_cycles, e_lat, e_vcyc);
      end
      n_checks++;
      if (rsp_unstable || obs_unstable || obs_instr) begin
        n_fail++; $display("FAIL rand_stability[%0d]: rsp_unstable=%0d bus_unstable=%0d instr=%0d expected 0/0/0",
                           c, rsp_unstable, obs_unstable, obs_instr);
      end
      if (e_vcyc > 0) begin
        n_checks++;
        if (obs_addr !== {ad[31:2], 2'b00} || obs_strb !== e_strb || (wr && obs_wdata !== e_wdata)) begin
          n_fail++; $display("FAIL rand_bus[%0d]: addr=%h wstrb=%b wdata=%h expected %h/%b/%h",
                             c, obs_addr, obs_strb, obs_wdata, {ad[31:2], 2'b00}, e_strb, e_wdata);
        end
      end
      model_commit(wr, sz, ad, wd, e_err);
    end
  endtask

  task automatic test_reset_mid_bus();
    int k;
    bit seen;
    logic [1:0]  e_err;
    logic [31:0] e_rdata, e_wdata;
    logic [3:0]  e_strb;
    int          e_lat, e_vcyc;
    cur_delay    = -1;
    valid_cycles = 0;
    @(negedge clk);
    k = 0;
    while (ifc.cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = 1'b0;
    ifc.cmd_size  = 2'd2;
    ifc.cmd_addr  = 32'h104;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    k = 0;
    while (valid_cycles < 3 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (valid_cycles < 3) begin n_fail++; $display("FAIL mid_bus_setup: valid_cycles=%0d expected >=3", valid_cycles); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (ifc.mem_valid !== 1'b0 || ifc.rsp_valid !== 1'b0 || ifc.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_bus_reset: mem_valid=%b rsp_valid=%b cmd_ready=%b expected 0/0/0",
                         ifc.mem_valid, ifc.rsp_valid, ifc.cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_bus_release_ready: got %b expected 1", ifc.cmd_ready); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b0 || ifc.mem_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL mid_bus_no_rsp: activity seen=1 expected 0"); end
    model_expect(1'b0, 2'd1, 32'h106, 32'h0, 1, e_err, e_rdata, e_lat, e_vcyc, e_strb, e_wdata);
    do_cmd(1'b0, 2'd1, 32'h106, 32'h0, 1, 0);
    n_checks++;
    if (obs_err !== e_err || obs_rdata !== e_rdata || obs_lat != e_lat) begin
      n_fail++; $display("FAIL mid_bus_recover: err=%0d rdata=%h lat=%0d expected %0d/%h/%0d",
                         obs_err, obs_rdata, obs_lat, e_err, e_rdata, e_lat);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_size  = 2'd0;
    ifc.cmd_addr  = 32'b0;
    ifc.cmd_wdata = 32'b0;
    ifc.rsp_ready = 1'b0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_read();
    test_errors();
    test_timeout();
    test_random(1000);
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
